i2c_slave_resp: RTL
===================

// Module: i2c_slave_resp
// PURPOSE
//  I2C responder (slave) for the bus driven by the team's I2C master. Oversamples SCL/SDA on the system clock.
//  Detects START/STOP and matches a fixed 7-bit address. Accepts write bytes (ACKs each one) and serves read bytes.
//  Sits between the I2C pins and a local register/FIFO interface. No clock stretching, no 10-bit addressing.
// PARAMETERS
//  SLAVE_ADDR  7'h42  7-bit bus address this block responds to
// PORTS
//  clk          input   1  system clock; must run >= 16x SCL frequency
//  rst_n        input   1  asynchronous, active-low reset
//  i2c_scl      input   1  bus clock (input only, never driven)
//  i2c_sda      inout   1  bus data; open-drain: driven 0 or released to 'bz
//  tx_data      input   8  byte to return on a read; sampled in the cycle tx_req=1
//  tx_req       output  1  one-clk pulse: tx_data is being loaded for the next read byte
//  rx_data      output  8  last byte received on a write; holds until the next write byte
//  rx_valid     output  1  one-clk pulse: rx_data updated
//  addr_hit     output  1  high from address match until STOP/START
//  busy         output  1  high between a detected START and a detected STOP
// BEHAVIOUR
//  Reset (rst_n=0, any time, async): state=IDLE, SDA released, tx_req=0, rx_valid=0, rx_data=0, addr_hit=0, busy=0.
//  Input sync: SCL and SDA each pass 2 FFs; edges come from sync'd vs previous sample.
//   Event latency is 3 clk from the pin edge.
//  START = sync'd SDA 1->0 while SCL=1; STOP = SDA 0->1 while SCL=1. Both are checked every cycle, in any state.
//   START (incl. repeated): -> ADDR, bitcnt=7, busy=1, addr_hit=0, SDA released.
//   STOP: -> IDLE, busy=0, addr_hit=0, SDA released. STOP takes precedence over any bit processing in that cycle.
//  Bit timing: sample SDA on SCL rise, change SDA drive on SCL fall. MSB first; bitcnt counts 7..0.
//  States:
//   IDLE     : SDA released; wait for START.
//   ADDR     : shift 8 bits {addr,rw}. After 8th rise: match -> ADDR_ACK (addr_hit=1); else -> WAIT_STOP.
//   ADDR_ACK : on next SCL fall drive SDA=0; on the following fall:
//              rw=0 -> release SDA, -> WR_DATA.
//              rw=1 -> pulse tx_req, load tx_data into shifter, drive bit7, -> RD_DATA.
//   WR_DATA  : shift 8 bits. On 8th rise: rx_data<=byte, rx_valid=1 for one clk, -> WR_ACK.
//   WR_ACK   : on next fall drive SDA=0; on the following fall release SDA, bitcnt=7, -> WR_DATA (multi-byte writes).
//   RD_DATA  : on each fall drive next bit (drive 0 or release for 1). After bit0 is held through its rise,
//              release SDA on the next fall, -> RD_ACK.
//   RD_ACK   : on SCL rise sample master ACK.
//              SDA=0 (ACK) -> pulse tx_req, load next byte, drive bit7 on the next fall, -> RD_DATA.
//              SDA=1 (NACK) -> WAIT_STOP.
//   WAIT_STOP: SDA released; leave only on STOP (-> IDLE) or START (-> ADDR).
//  SCL edges seen in IDLE are ignored; SDA edges while SCL=0 are data, not START/STOP.
//  SDA drive update: registered; never glitches to 0 while SCL is high except in ACK/RD bit slots.
//  Simultaneous rx_valid and tx_req cannot occur. The tx_req pulse is the same clk as the shifter load.
// TESTING
//  1 Reset: hold rst_n=0 mid-transfer (RD_DATA driving 0) -> SDA='bz in same cycle; all outputs 0; next START works.
//  2 Write: START, 0x84 (0x42,W), 0xA5, STOP -> ACK=0 at both ACK slots; rx_valid once with rx_data=8'hA5; busy 1->0.
//  3 Addr miss: START, 0x86 (0x43,W), 0xFF -> SDA released through both ACK slots; no rx_valid; addr_hit=0.
//  4 Read: START, 0x85, tx_data=0x3C, master ACK, tx_data=0xC3, master NACK, STOP
//      -> bytes 0x3C then 0xC3 on SDA; tx_req pulsed exactly twice; SDA released after the NACK.
//  5 Repeated start: START, 0x84, 0x11, START, 0x85 (no STOP)
//      -> rx_data=0x11; address re-matched; tx_req pulse; read proceeds.
//  6 Stray STOP mid-byte: START, 0x84, 4 data bits, STOP -> IDLE; no rx_valid; busy=0; SDA released.

Source files
------------

// File: rtl/i2c_slave_resp.sv
// i2c_slave_resp: oversampled I2C responder at a fixed 7-bit address; ACKs writes and emits rx_data/rx_valid, serves read bytes requested through tx_req/tx_data, and reports addr_hit/busy.
module i2c_slave_resp #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP} state_t;
  state_t state, state_n;
  logic [1:0] scl_sync, sda_sync;
  logic scl_p, sda_p, scl_s, sda_s;
  logic rise, fall, start, stop;
  logic [2:0] bitcnt, bitcnt_n;
  logic [7:0] shreg, sh_n, shift, rx_n;
  logic sda_oe, oe_n, ph, ph_n, rxv_n, hit_n, busy_n;
  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
  assign rise = scl_s & ~scl_p;
  assign fall = ~scl_s & scl_p;
  assign start = scl_s & scl_p & sda_p & ~sda_s;
  assign stop = scl_s & scl_p & ~sda_p & sda_s;
  assign shift = {shreg[6:0], sda_s};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
      state    <= IDLE;
      bitcnt   <= 3'd7;
      shreg    <= 8'h00;
      sda_oe   <= 1'b0;
      ph       <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      addr_hit <= 1'b0;
      busy     <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], i2c_scl};
      sda_sync <= {sda_sync[0], i2c_sda};
      scl_p    <= scl_s;
      sda_p    <= sda_s;
      state    <= state_n;
      bitcnt   <= bitcnt_n;
      shreg    <= sh_n;
      sda_oe   <= oe_n;
      ph       <= ph_n;
      rx_data  <= rx_n;
      rx_valid <= rxv_n;
      addr_hit <= hit_n;
      busy     <= busy_n;
    end
  end
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    sh_n     = shreg;
    oe_n     = sda_oe;
    ph_n     = ph;
    rx_n     = rx_data;
    rxv_n    = 1'b0;
    tx_req   = 1'b0;
    hit_n    = addr_hit;
    busy_n   = busy;
    if (stop) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      hit_n   = 1'b0;
      oe_n    = 1'b0;
    end else if (start) begin
      state_n  = ADDR;
      bitcnt_n = 3'd7;
      busy_n   = 1'b1;
      hit_n    = 1'b0;
      oe_n     = 1'b0;
      ph_n     = 1'b0;
    end else begin
      unique case (state)
        ADDR: if (rise) begin
          sh_n     = shift;
          bitcnt_n = bitcnt - 3'd1;
          if (bitcnt == 3'd0) begin
            hit_n   = shift[7:1] == SLAVE_ADDR;
            state_n = (shift[7:1] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
            ph_n    = 1'b0;
          end
        end
        ADDR_ACK: if (fall) begin
          if (!ph) begin
            oe_n = 1'b1;
            ph_n = 1'b1;
          end else if (!shreg[0]) begin
            oe_n     = 1'b0;
            bitcnt_n = 3'd7;
            state_n  = WR_DATA;
          end else begin
            tx_req   = 1'b1;
            sh_n     = tx_data;
            oe_n     = ~tx_data[7];
            bitcnt_n = 3'd7;
            ph_n     = 1'b0;
            state_n  = RD_DATA;
          end
        end
        WR_DATA: if (rise) begin
          sh_n     = shift;
          bitcnt_n = bitcnt - 3'd1;
          if (bitcnt == 3'd0) begin
            rx_n    = shift;
            rxv_n   = 1'b1;
            ph_n    = 1'b0;
            state_n = WR_ACK;
          end
        end
        WR_ACK: if (fall) begin
          oe_n     = ~ph;
          ph_n     = ~ph;
          bitcnt_n = 3'd7;
          state_n  = ph ? WR_DATA : WR_ACK;
        end
        // ph marks that bit0 has been sampled; the next fall hands SDA to the master for its ACK
        RD_DATA: if (rise) begin
          bitcnt_n = bitcnt - 3'd1;
          ph_n     = bitcnt == 3'd0;
        end else if (fall) begin
          oe_n    = ~ph & ~shreg[bitcnt];
          state_n = ph ? RD_ACK : RD_DATA;
          ph_n    = 1'b0;
        end
        RD_ACK: if (rise) begin
          if (!sda_s) begin
            tx_req   = 1'b1;
            sh_n     = tx_data;
            bitcnt_n = 3'd7;
            ph_n     = 1'b0;
            state_n  = RD_DATA;
          end else begin
            state_n = WAIT_STOP;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
